// File: rtl/flexbex_efpga_cfu_ctrl.sv
// eFPGA custom-function-unit sequencer: launches one fabric operation per accepted instruction
// and returns a selected result after a fixed delay or a fabric done handshake (with timeout).
module flexbex_efpga_cfu_ctrl #(
    parameter int N_OPS   = 2,
    parameter int N_RES   = 3,
    parameter int OP_W    = 2,
    parameter int DELAY_W = 4,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  flush_i,
    input  logic [OP_W-1:0]       operator_i,
    input  logic [DELAY_W-1:0]    delay_i,
    input  logic [SEL_W-1:0]      res_sel_i,
    input  logic [N_OPS*32-1:0]   operands_i,
    output logic [N_OPS*32-1:0]   efpga_operands_o,
    output logic [OP_W-1:0]       efpga_operator_o,
    output logic                  efpga_write_strobe_o,
    input  logic                  efpga_done_i,
    input  logic [N_RES*32-1:0]   efpga_results_i,
    output logic [31:0]           result_o,
    output logic                  ready_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic [1:0]            dbg_state
);

    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int CNT_W = (DELAY_W > TO_W) ? DELAY_W : TO_W;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [N_OPS*32-1:0] ops_q;
    logic [OP_W-1:0]     op_q;
    logic [DELAY_W-1:0]  delay_q;
    logic [SEL_W-1:0]    sel_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [31:0]         result_q;
    logic                err_q;
    logic                complete;
    logic                timeout;
    logic [31:0]         sel_result;

    // Handshake: en_i is a request sampled only in IDLE (no back-pressure signal); ready_o is a
    // one-cycle pulse in RESP, and result_o/err_o stay valid from that pulse until the next one.
    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            IDLE:   if (en_i && !flush_i) state_d = LAUNCH;
            LAUNCH: state_d = flush_i ? IDLE : WAIT;
            WAIT: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    if (delay_q != '0) begin
                        complete = (cnt_q == CNT_W'(delay_q));
                    end else if (efpga_done_i) begin
                        complete = 1'b1;
                    end else if (cnt_q == TIMEOUT_C) begin
                        complete = 1'b1;
                        timeout  = 1'b1;
                    end
                    if (complete) state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        sel_result = '0;
        for (int k = 0; k < N_RES; k++) begin
            if (int'(sel_q) == k) sel_result = efpga_results_i[k*32 +: 32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ops_q    <= '0;
            op_q     <= '0;
            delay_q  <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && en_i && !flush_i) begin
                ops_q   <= operands_i;
                op_q    <= operator_i;
                delay_q <= delay_i;
                sel_q   <= res_sel_i;
                cnt_q   <= '0;
            end
            if (state_q == LAUNCH) cnt_q <= CNT_W'(1);
            if (state_q == WAIT && !complete) cnt_q <= cnt_q + CNT_W'(1);
            if (complete) begin
                result_q <= timeout ? 32'd0 : sel_result;
                err_q    <= timeout;
            end
        end
    end

    assign efpga_operands_o     = ops_q;
    assign efpga_operator_o     = op_q;
    assign efpga_write_strobe_o = (state_q == LAUNCH) && !flush_i;
    assign ready_o              = (state_q == RESP) && !flush_i;
    assign result_o             = result_q;
    assign err_o                = err_q;
    assign busy_o               = (state_q != IDLE);
    assign dbg_state            = state_q;

endmodule

// File: tb/tb_flexbex_efpga_cfu_ctrl.sv
// Directed bench for flexbex_efpga_cfu_ctrl: expected {cycle, err, result} tuples are queued at
// issue time and popped by a monitor on every ready_o pulse.
module tb_flexbex_efpga_cfu_ctrl;

    localparam int EW = 65;
    localparam logic [31:0] RES0 = 32'h1111_0000;
    localparam logic [31:0] RES1 = 32'h0000_CAFE;
    localparam logic [31:0] RES2 = 32'h2222_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [1:0]  operator_i = '0;
    logic [3:0]  delay_i = '0;
    logic [1:0]  res_sel_i = '0;
    logic [63:0] operands_i = '0;
    logic [63:0] efpga_operands_o;
    logic [1:0]  efpga_operator_o;
    logic        efpga_write_strobe_o;
    logic        efpga_done_i = 1'b0;
    logic [95:0] efpga_results_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        err_o;
    logic        busy_o;
    logic [1:0]  dbg_state;

    logic [EW-1:0] exp_q[$];
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int t0;

    assign efpga_results_i = {RES2, RES1, RES0};

    flexbex_efpga_cfu_ctrl #(
        .N_OPS(2), .N_RES(3), .OP_W(2), .DELAY_W(4), .SEL_W(2), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .flush_i(flush_i),
        .operator_i(operator_i), .delay_i(delay_i), .res_sel_i(res_sel_i),
        .operands_i(operands_i), .efpga_operands_o(efpga_operands_o),
        .efpga_operator_o(efpga_operator_o), .efpga_write_strobe_o(efpga_write_strobe_o),
        .efpga_done_i(efpga_done_i), .efpga_results_i(efpga_results_i),
        .result_o(result_o), .ready_o(ready_o), .err_o(err_o), .busy_o(busy_o),
        .dbg_state(dbg_state)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, act=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: act=0x%0h exp=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ready_o pulse must match the oldest queued expectation, including its cycle.
    always @(negedge clk) begin
        if (ready_o) begin
            logic [EW-1:0] e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_ready: act=ready@%0d exp=no ready", cyc);
            end else begin
                e = exp_q.pop_front();
                if ({32'(cyc), err_o, result_o} !== e) begin
                    n_err++;
                    $display("FAIL resp: act cyc=%0d err=%0b res=0x%0h exp cyc=%0d err=%0b res=0x%0h",
                             cyc, err_o, result_o, e[64:33], e[32], e[31:0]);
                end
            end
        end
    end

    // Driver: call at posedge+#1; returns at posedge+#1 of the LAUNCH cycle.
    task automatic issue(input logic [1:0] op, input logic [3:0] dly, input logic [1:0] sel,
                         input logic [31:0] a, input logic [31:0] b, input bit push,
                         input logic [31:0] exp_res, input logic exp_err, input int lat);
        t0 = cyc;
        if (push) exp_q.push_back({32'(t0 + lat), exp_err, exp_res});
        en_i = 1'b1; operator_i = op; delay_i = dly; res_sel_i = sel; operands_i = {b, a};
        @(posedge clk); #1;
        en_i = 1'b0; operator_i = '0; delay_i = '0; res_sel_i = '0; operands_i = '0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!busy_o) break;
        end
        if (i == 40) check({name, "_idle_timeout"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        operands_i = {32'hDEAD_0001, 32'hDEAD_0002};
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_strobe", 64'(efpga_write_strobe_o), 64'd0);
        check("rst_result", {31'd0, err_o, result_o}, 64'd0);
        check("rst_fabric", efpga_operands_o | 64'(efpga_operator_o), 64'd0);
        operands_i = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: fixed delay 3
        issue(2'd2, 4'd3, 2'd1, 32'd5, 32'd7, 1'b1, RES1, 1'b0, 5);
        check("t1_strobe_launch", 64'(efpga_write_strobe_o), 64'd1);
        check("t1_operands", efpga_operands_o, {32'd7, 32'd5});
        check("t1_operator", 64'(efpga_operator_o), 64'd2);
        check("t1_busy", 64'(busy_o), 64'd1);
        @(posedge clk); #1;
        check("t1_strobe_wait", 64'(efpga_write_strobe_o), 64'd0);
        wait_idle("t1");

        // 2: done mode, done_i high in LAUNCH must not complete
        issue(2'd1, 4'd0, 2'd2, 32'd9, 32'd3, 1'b1, RES2, 1'b0, 7);
        efpga_done_i = 1'b1;
        @(posedge clk); #1;
        efpga_done_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        efpga_done_i = 1'b1;
        @(posedge clk); #1;
        efpga_done_i = 1'b0;
        wait_idle("t2");

        // 3: timeout, then clean op clears err
        issue(2'd0, 4'd0, 2'd1, 32'd1, 32'd2, 1'b1, 32'd0, 1'b1, 10);
        wait_idle("t3a");
        check("t3_err_held", {31'd0, err_o, result_o}, {31'd0, 1'b1, 32'd0});
        issue(2'd3, 4'd2, 2'd0, 32'd4, 32'd4, 1'b1, RES0, 1'b0, 4);
        wait_idle("t3b");

        // 4: flush in WAIT, flush in LAUNCH, then normal op
        issue(2'd1, 4'd5, 2'd1, 32'd6, 32'd6, 1'b0, 32'd0, 1'b0, 0);
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("t4_busy_after_flush", 64'(busy_o), 64'd0);
        issue(2'd1, 4'd2, 2'd1, 32'd6, 32'd6, 1'b0, 32'd0, 1'b0, 0);
        flush_i = 1'b1;
        #1;
        check("t4_strobe_flushed", 64'(efpga_write_strobe_o), 64'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("t4_busy_launch_flush", 64'(busy_o), 64'd0);
        issue(2'd0, 4'd1, 2'd2, 32'd8, 32'd8, 1'b1, RES2, 1'b0, 3);
        wait_idle("t4");

        // 5: back-to-back delay=1, sel 0, 2, then out-of-range 3
        issue(2'd0, 4'd1, 2'd0, 32'd1, 32'd1, 1'b1, RES0, 1'b0, 3);
        repeat (3) @(posedge clk);
        #1;
        issue(2'd0, 4'd1, 2'd2, 32'd2, 32'd2, 1'b1, RES2, 1'b0, 3);
        repeat (3) @(posedge clk);
        #1;
        issue(2'd0, 4'd1, 2'd3, 32'd3, 32'd3, 1'b1, 32'd0, 1'b0, 3);
        wait_idle("t5");

        // 6: async reset during WAIT
        issue(2'd2, 4'd1, 2'd1, 32'd5, 32'd5, 1'b1, RES1, 1'b0, 3);
        wait_idle("t6a");
        check("t6_result_held", 64'(result_o), 64'(RES1));
        issue(2'd2, 4'd5, 2'd2, 32'hA, 32'hB, 1'b0, 32'd0, 1'b0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 64'(busy_o), 64'd0);
        check("t6_rst_result", {31'd0, err_o, result_o}, 64'd0);
        check("t6_rst_fabric", efpga_operands_o | 64'(efpga_operator_o), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(2'd1, 4'd2, 2'd2, 32'hC, 32'hD, 1'b1, RES2, 1'b0, 4);
        wait_idle("t6b");

        repeat (4) @(posedge clk);
        #1;
        check("leftover_expected", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
